// File: rtl/oflow_iou_min_select_pkg.sv
// Shared types and constants for the oflow IoU minimum-cost selector.
// Contents: FSM state enum, default cost width, and the all-ones cost value
// that stands for "no candidate seen yet".
package oflow_iou_select_pkg;

   localparam int unsigned DEFAULT_IOU_LEN = 22;

   // Worst possible cost: q0.22 all ones. It never beats a stored best cost.
   localparam logic [DEFAULT_IOU_LEN-1:0] COST_MAX = {DEFAULT_IOU_LEN{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

endpackage

// File: rtl/oflow_iou_min_select_if.sv
// Handshake between the minimum-cost selector and the IoU calculator.
//   start_iou : selector -> calculator, one-cycle launch pulse
//   hist_idx  : selector -> history bbox mux, candidate under evaluation
//   valid_iou : calculator -> selector, one-cycle result strobe
//   iou       : calculator -> selector, cost (1 - IoU) in q0.IOU_LEN
// modport master is the selector side, modport slave the calculator side.
interface oflow_iou_min_select_if
   import oflow_iou_select_pkg::*;
#(
   parameter int unsigned NUM_HISTORY = 8,
   parameter int unsigned IOU_LEN     = DEFAULT_IOU_LEN
);
   localparam int unsigned IDX_LEN = $clog2(NUM_HISTORY);

   logic               start_iou;
   logic [IDX_LEN-1:0] hist_idx;
   logic               valid_iou;
   logic [IOU_LEN-1:0] iou;

   modport master (
      output start_iou,
      output hist_idx,
      input  valid_iou,
      input  iou
   );

   modport slave (
      input  start_iou,
      input  hist_idx,
      output valid_iou,
      output iou
   );

endinterface

// File: rtl/oflow_min_tracker.sv
// Running minimum of candidate costs with the index of the first minimum.
//   clk, reset_N : clock and synchronous active-high reset
//   clear        : reload best_cost with all ones and best_idx with 0
//   upd_en       : offer (cost, idx); taken only if strictly lower
//   best_cost    : registered minimum cost
//   best_idx     : registered index of that minimum
// Strict compare means the earliest (lowest-index) candidate wins a tie.
module oflow_min_tracker
   import oflow_iou_select_pkg::*;
#(
   parameter int unsigned IOU_LEN = DEFAULT_IOU_LEN,
   parameter int unsigned IDX_LEN = 3
) (
   input  logic               clk,
   input  logic               reset_N,
   input  logic               clear,
   input  logic               upd_en,
   input  logic [IOU_LEN-1:0] cost,
   input  logic [IDX_LEN-1:0] idx,
   output logic [IOU_LEN-1:0] best_cost,
   output logic [IDX_LEN-1:0] best_idx
);

   localparam logic [IOU_LEN-1:0] CostMax = {IOU_LEN{1'b1}};

   logic [IOU_LEN-1:0] best_cost_q, best_cost_d;
   logic [IDX_LEN-1:0] best_idx_q, best_idx_d;

   // Next best: clear has priority over an update offered in the same cycle.
   always_comb begin
      best_cost_d = best_cost_q;
      best_idx_d  = best_idx_q;
      if (clear) begin
         best_cost_d = CostMax;
         best_idx_d  = '0;
      end else if (upd_en && (cost < best_cost_q)) begin
         best_cost_d = cost;
         best_idx_d  = idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset_N) begin
         best_cost_q <= CostMax;
         best_idx_q  <= '0;
      end else begin
         best_cost_q <= best_cost_d;
         best_idx_q  <= best_idx_d;
      end
   end

   assign best_cost = best_cost_q;
   assign best_idx  = best_idx_q;

endmodule

// File: rtl/oflow_iou_min_select.sv
// Sequences up to NUM_HISTORY history candidates through the IoU calculator
// for one frame-k bbox, keeps the minimum cost and its index, and reports the
// best match plus a threshold decision when the query completes.
//   clk, reset_N    : clock, synchronous active-high reset
//   start           : query launch pulse, ignored unless idle
//   num_candidates  : candidate count (clamped to NUM_HISTORY), sampled at start
//   cost_threshold  : match threshold, sampled at start
//   busy, done      : query in progress / one-cycle result strobe
//   match_found     : best_cost <= threshold with at least one candidate
//   best_idx/cost   : minimum-cost candidate, held until the next start
//   timeout_err     : sticky watchdog flag (OFLOW_IOU_TIMEOUT_EN only)
//   calc            : calculator handshake (start_iou, hist_idx, valid_iou, iou)
// Optional feature macro: OFLOW_IOU_TIMEOUT_EN adds a WAIT watchdog that
// retires a silent candidate as cost all ones after TIMEOUT_CYCLES.
module oflow_iou_min_select
   import oflow_iou_select_pkg::*;
#(
   parameter int unsigned NUM_HISTORY = 8,
   parameter int unsigned IOU_LEN     = DEFAULT_IOU_LEN,
   parameter int unsigned IDX_LEN     = $clog2(NUM_HISTORY)
`ifdef OFLOW_IOU_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
   input  logic               clk,
   input  logic               reset_N,
   input  logic               start,
   input  logic [IDX_LEN:0]   num_candidates,
   input  logic [IOU_LEN-1:0] cost_threshold,
   output logic               busy,
   output logic               done,
   output logic               match_found,
   output logic [IDX_LEN-1:0] best_idx,
   output logic [IOU_LEN-1:0] best_cost,
`ifdef OFLOW_IOU_TIMEOUT_EN
   output logic               timeout_err,
`endif
   oflow_iou_min_select_if.master calc
);

   localparam int unsigned CNT_LEN = IDX_LEN + 1;
   localparam logic [IOU_LEN-1:0] CostMax = {IOU_LEN{1'b1}};

   state_e             state_q, state_d;
   logic [CNT_LEN-1:0] cnt_q, cnt_d;
   logic [IOU_LEN-1:0] thr_q, thr_d;
   logic [IDX_LEN-1:0] hist_idx_q, hist_idx_d;
   logic               start_iou_q, start_iou_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               match_q, match_d;

   logic               trk_clear, trk_upd;
   logic [IOU_LEN-1:0] trk_best_cost;
   logic [IDX_LEN-1:0] trk_best_idx;

   logic [CNT_LEN-1:0] num_clamped_c;
   logic               timeout_hit_c;
   logic               cand_done_c;
   logic [IOU_LEN-1:0] cand_cost_c;
   logic [IOU_LEN-1:0] new_best_c;
   logic               last_c;

   assign num_clamped_c = (num_candidates > CNT_LEN'(NUM_HISTORY)) ? CNT_LEN'(NUM_HISTORY)
                                                                    : num_candidates;

   // A candidate retires on its result strobe or, with the watchdog, on timeout.
   assign cand_done_c = (state_q == ST_WAIT) && (calc.valid_iou || timeout_hit_c);
   assign cand_cost_c = calc.valid_iou ? calc.iou : CostMax;
   assign last_c      = (CNT_LEN'(hist_idx_q) == (cnt_q - CNT_LEN'(1)));

   // Best cost as it will stand after this cycle's update; feeds match_found
   // so the decision is registered in the same edge as the final best_cost.
   assign new_best_c  = (cand_cost_c < trk_best_cost) ? cand_cost_c : trk_best_cost;

`ifdef OFLOW_IOU_TIMEOUT_EN
   localparam int unsigned WCNT_LEN = $clog2(TIMEOUT_CYCLES + 1);

   logic [WCNT_LEN-1:0] wait_cnt_q, wait_cnt_d;
   logic                timeout_err_q, timeout_err_d;

   // Fires in the TIMEOUT_CYCLES-th WAIT cycle without a result strobe.
   assign timeout_hit_c = (state_q == ST_WAIT) && !calc.valid_iou &&
                          (wait_cnt_q == WCNT_LEN'(TIMEOUT_CYCLES - 1));

   always_comb begin
      wait_cnt_d    = '0;
      timeout_err_d = timeout_err_q | timeout_hit_c;
      if ((state_q == ST_WAIT) && !cand_done_c) begin
         wait_cnt_d = wait_cnt_q + WCNT_LEN'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset_N) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign timeout_hit_c = 1'b0;
`endif

   // Next state and next registered outputs.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      thr_d       = thr_q;
      hist_idx_d  = hist_idx_q;
      start_iou_d = 1'b0;
      done_d      = 1'b0;
      busy_d      = busy_q;
      match_d     = match_q;
      trk_clear   = 1'b0;
      trk_upd     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               trk_clear  = 1'b1;
               match_d    = 1'b0;
               busy_d     = 1'b1;
               hist_idx_d = '0;
               thr_d      = cost_threshold;
               cnt_d      = num_clamped_c;
               if (num_clamped_c == '0) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d     = ST_ISSUE;
                  start_iou_d = 1'b1;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (cand_done_c) begin
               trk_upd = 1'b1;
               if (last_c) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  // Count is non-zero on this path, so only the threshold matters.
                  match_d = (new_best_c <= thr_q);
               end else begin
                  state_d     = ST_ISSUE;
                  start_iou_d = 1'b1;
                  hist_idx_d  = hist_idx_q + IDX_LEN'(1);
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset_N) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         thr_q       <= '0;
         hist_idx_q  <= '0;
         start_iou_q <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         match_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         thr_q       <= thr_d;
         hist_idx_q  <= hist_idx_d;
         start_iou_q <= start_iou_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         match_q     <= match_d;
      end
   end

   oflow_min_tracker #(
      .IOU_LEN (IOU_LEN),
      .IDX_LEN (IDX_LEN)
   ) u_min_tracker (
      .clk       (clk),
      .reset_N   (reset_N),
      .clear     (trk_clear),
      .upd_en    (trk_upd),
      .cost      (cand_cost_c),
      .idx       (hist_idx_q),
      .best_cost (trk_best_cost),
      .best_idx  (trk_best_idx)
   );

   assign calc.start_iou = start_iou_q;
   assign calc.hist_idx  = hist_idx_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign match_found    = match_q;
   assign best_cost      = trk_best_cost;
   assign best_idx       = trk_best_idx;

endmodule
